// File: rtl/ttt_dot_driver.sv
// Row-scanning dot-matrix driver for the tic-tac-toe board: 9 glyph cells, grid lines and a turn row.
// Define TTT_DOT_BLINK_EN to build the winning-line blink logic; without it win_mask is ignored.
//
// state | meaning
// IDLE  | after reset, waiting for the first scan tick
// SCAN  | showing row row_q (0..9), advancing one row per tick
module ttt_dot_driver #(
    parameter int CLK_DIV      = 12499,
    parameter int BLINK_FRAMES = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [17:0] board,
    input  logic        turn_o,
    input  logic [8:0]  win_mask,
    output logic [9:0]  dot_row,
    output logic [13:0] dot_col,
    output logic        frame_start
);

    localparam int DIV_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               tick;
    logic               enter_row0;

    logic [17:0]        board_sh_q, board_sh_d;
    logic               turn_sh_q, turn_sh_d;
    logic [8:0]         blank_sh_q, blank_sh_d;

    logic [17:0]        src_board;
    logic               src_turn;
    logic [8:0]         src_blank;
    logic [8:0]         snap_blank;

    logic [9:0]         dot_row_q, dot_row_d;
    logic [13:0]        dot_col_q, dot_col_d;
    logic               frame_start_q, frame_start_d;

    function automatic logic [13:0] render_row(input logic [3:0]  r,
                                                input logic [17:0] b,
                                                input logic        t,
                                                input logic [8:0]  blank);
        logic [13:0] col;
        logic [1:0]  code;
        logic [3:0]  g;
        int          cr;
        int          gr;
        int          k;
        col = '0;
        if (r == 4'd9) begin
            col = t ? 14'b11110000000000 : 14'b00000000001111;
        end else begin
            cr = int'(r) / 3;
            gr = int'(r) % 3;
            col[4] = 1'b1;
            col[9] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                k    = cr * 3 + c;
                code = b[2*k +: 2];
                if (blank[k]) code = 2'b00;
                case (code)
                    2'b01:   g = (gr == 1) ? 4'b0110 : 4'b1001;
                    2'b10:   g = (gr == 1) ? 4'b1001 : 4'b0110;
                    2'b11:   g = 4'b1111;
                    default: g = 4'b0000;
                endcase
                col[5*c +: 4] = g;
            end
        end
        return col;
    endfunction

    assign tick      = (div_cnt_q == DIV_W'(CLK_DIV));
    assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        enter_row0 = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    state_d    = SCAN;
                    row_d      = '0;
                    enter_row0 = 1'b1;
                end
                SCAN: begin
                    if (row_q == 4'd9) begin
                        row_d      = '0;
                        enter_row0 = 1'b1;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef TTT_DOT_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    // The frame being snapshotted renders with the phase held before this snapshot's update.
    assign snap_blank = blink_phase_q ? win_mask : 9'd0;

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (enter_row0) begin
            if (win_mask == 9'd0) begin
                frame_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    localparam int BLINK_FRAMES_UNUSED = BLINK_FRAMES;
    logic win_mask_unused;
    assign win_mask_unused = ^win_mask;
    assign snap_blank      = 9'd0;
`endif

    // Row 0 is built from the live inputs on the snapshot edge; later rows use the shadows.
    assign src_board = enter_row0 ? board      : board_sh_q;
    assign src_turn  = enter_row0 ? turn_o     : turn_sh_q;
    assign src_blank = enter_row0 ? snap_blank : blank_sh_q;

    always_comb begin
        board_sh_d    = board_sh_q;
        turn_sh_d     = turn_sh_q;
        blank_sh_d    = blank_sh_q;
        frame_start_d = enter_row0;
        dot_row_d     = dot_row_q;
        dot_col_d     = dot_col_q;
        if (enter_row0) begin
            board_sh_d = board;
            turn_sh_d  = turn_o;
            blank_sh_d = snap_blank;
        end
        if (!en) begin
            dot_row_d = '0;
            dot_col_d = '0;
        end else if (tick) begin
            dot_row_d = 10'd1 << row_d;
            dot_col_d = render_row(row_d, src_board, src_turn, src_blank);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            div_cnt_q     <= '0;
            board_sh_q    <= '0;
            turn_sh_q     <= 1'b0;
            blank_sh_q    <= '0;
            dot_row_q     <= '0;
            dot_col_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            div_cnt_q     <= div_cnt_d;
            board_sh_q    <= board_sh_d;
            turn_sh_q     <= turn_sh_d;
            blank_sh_q    <= blank_sh_d;
            dot_row_q     <= dot_row_d;
            dot_col_q     <= dot_col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dot_row     = dot_row_q;
    assign dot_col     = dot_col_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ttt_dot_driver.sv
// Directed bench for ttt_dot_driver at CLK_DIV=3 (4 clk per row, 40 clk per frame), BLINK_FRAMES=2.
module tb_ttt_dot_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [17:0] board = '0;
    logic        turn_o = 1'b0;
    logic [8:0]  win_mask = '0;
    logic [9:0]  dot_row;
    logic [13:0] dot_col;
    logic        frame_start;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [13:0] GRID = 14'h0210;

    typedef struct {
        logic [17:0] board;
        logic        turn;
        logic [8:0]  mask;
        int          row;
        logic [13:0] col;
    } vec_t;

    vec_t        vecs [16];
    logic [13:0] blink_exp [6];

    ttt_dot_driver #(.CLK_DIV(3), .BLINK_FRAMES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .board       (board),
        .turn_o      (turn_o),
        .win_mask    (win_mask),
        .dot_row     (dot_row),
        .dot_col     (dot_col),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (frame_start) ok = 1'b1;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic release_and_check_first(input string tag);
        int bad;
        bad = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (dot_row !== 10'd0 || dot_col !== 14'd0 || frame_start !== 1'b0) bad++;
        end
        check({tag, "_dark_cycles"}, bad, 0);
        step(1);
        check({tag, "_first_row"}, {22'd0, dot_row}, 32'h001);
        check({tag, "_first_col"}, {18'd0, dot_col}, {18'd0, GRID});
        check({tag, "_first_fs"}, {31'd0, frame_start}, 32'd1);
        step(1);
        check({tag, "_fs_drop"}, {31'd0, frame_start}, 32'd0);
    endtask

    initial begin
        int bad;
        vecs[0]  = '{18'h00000, 1'b0, 9'h000, 0, 14'h0210};
        vecs[1]  = '{18'h00000, 1'b0, 9'h000, 9, 14'h000F};
        vecs[2]  = '{18'h00000, 1'b1, 9'h000, 9, 14'h3C00};
        vecs[3]  = '{18'h20001, 1'b0, 9'h000, 0, 14'h0219};
        vecs[4]  = '{18'h20001, 1'b0, 9'h000, 7, 14'h2610};
        vecs[5]  = '{18'h20001, 1'b0, 9'h000, 8, 14'h1A10};
        vecs[6]  = '{18'h20001, 1'b0, 9'h000, 9, 14'h000F};
        vecs[7]  = '{18'h00300, 1'b0, 9'h000, 4, 14'h03F0};
        vecs[8]  = '{18'h00300, 1'b0, 9'h000, 3, 14'h03F0};
        vecs[9]  = '{18'h00400, 1'b0, 9'h000, 4, 14'h1A10};
        vecs[10] = '{18'h00008, 1'b0, 9'h000, 1, 14'h0330};
        vecs[11] = '{18'h00008, 1'b0, 9'h000, 0, 14'h02D0};
        vecs[12] = '{18'h00000, 1'b1, 9'h1FF, 0, 14'h0210};
        vecs[13] = '{18'h00001, 1'b1, 9'h000, 2, 14'h0219};
        vecs[14] = '{18'h3FFFF, 1'b0, 9'h000, 5, 14'h3FFF};
        vecs[15] = '{18'h00010, 1'b0, 9'h000, 1, 14'h1A10};
`ifdef TTT_DOT_BLINK_EN
        blink_exp = '{14'h0219, 14'h0219, 14'h0210, 14'h0210, 14'h0219, 14'h0219};
`else
        blink_exp = '{14'h0219, 14'h0219, 14'h0219, 14'h0219, 14'h0219, 14'h0219};
`endif

        // reset and first frame
        #2 rst = 1'b0;
        #20;
        check("reset_row", {22'd0, dot_row}, 32'd0);
        check("reset_col", {18'd0, dot_col}, 32'd0);
        check("reset_fs", {31'd0, frame_start}, 32'd0);
        release_and_check_first("boot");

        // row sequence, one-hot and frame period
        wait_frame("seq_fs");
        bad = 0;
        for (int i = 1; i < 80; i++) begin
            step(1);
            if (!$onehot(dot_row) || dot_row !== (10'd1 << ((i / 4) % 10))
                || frame_start !== (i % 40 == 0)) bad++;
        end
        check("row_seq", bad, 0);

        // table vectors: inputs set mid-frame, captured at the next snapshot
        foreach (vecs[v]) begin
            board    = vecs[v].board;
            turn_o   = vecs[v].turn;
            win_mask = vecs[v].mask;
            wait_frame($sformatf("vec%0d_fs", v));
            step(vecs[v].row * 4);
            check($sformatf("vec%0d_row", v), {22'd0, dot_row}, 32'd1 << vecs[v].row);
            check($sformatf("vec%0d_col", v), {18'd0, dot_col}, {18'd0, vecs[v].col});
        end

        // snapshot isolation
        board = '0; turn_o = 1'b0; win_mask = '0;
        wait_frame("snap_fs0");
        wait_frame("snap_fs1");
        step(8);
        board = 18'h00100;
        step(8);
        check("snap_same_frame_row", {22'd0, dot_row}, 32'h010);
        check("snap_same_frame_col", {18'd0, dot_col}, {18'd0, GRID});
        wait_frame("snap_fs2");
        step(12);
        check("snap_next_r3", {18'd0, dot_col}, 32'h0330);
        step(4);
        check("snap_next_r4", {18'd0, dot_col}, 32'h02D0);

        // blink on the diagonal
        board    = 18'h10101;
        win_mask = 9'h111;
        for (int f = 0; f < 6; f++) begin
            wait_frame($sformatf("blink%0d_fs", f));
            check($sformatf("blink%0d_r0", f), {18'd0, dot_col}, {18'd0, blink_exp[f]});
            step(36);
            check($sformatf("blink%0d_r9", f), {18'd0, dot_col}, 32'h000F);
        end

        // enable
        board = '0; win_mask = '0;
        wait_frame("en_fs0");
        wait_frame("en_fs1");
        en = 1'b0;
        step(1);
        check("en_off_row", {22'd0, dot_row}, 32'd0);
        check("en_off_col", {18'd0, dot_col}, 32'd0);
        wait_frame("en_off_fs_keeps");
        check("en_off_dark", {8'd0, dot_row, dot_col}, 32'd0);
        en = 1'b1;
        step(1);
        check("en_back_wait", {22'd0, dot_row}, 32'd0);
        step(3);
        check("en_back_row", {22'd0, dot_row}, 32'h002);
        check("en_back_col", {18'd0, dot_col}, {18'd0, GRID});

        // asynchronous reset mid-frame
        step(5);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", {7'd0, frame_start, dot_row, dot_col}, 32'd0);
        #20;
        release_and_check_first("rerun");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
